// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator (default 640x480@60) feeding the sphere renderer.
//   Free-running horizontal/vertical counters, decoded display-enable and
//   line/frame strobes, a wrapping frame counter for the animation, and a
//   per-signal delay line that lines sync/blank up with the renderer's pixel
//   pipeline latency.
//
// Ports:
//   clk          in   pixel clock
//   rst_n        in   synchronous active-low reset
//   hpos         out  current pixel column, 0..H_TOTAL-1
//   vpos         out  current line, 0..V_TOTAL-1
//   display_on   out  visible-area decode (undelayed)
//   line_start   out  high while hpos==0
//   frame_start  out  high while hpos==0 and vpos==0
//   frame_cnt    out  frames completed since reset, wraps
//   hsync_d      out  hsync (polarity applied) delayed PIPE_DELAY cycles
//   vsync_d      out  vsync (polarity applied) delayed PIPE_DELAY cycles
//   display_on_d out  display_on delayed PIPE_DELAY cycles
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int PIPE_DELAY      = 2,
  parameter int FRAME_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [9:0]         hpos,
  output logic [9:0]         vpos,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               hsync_d,
  output logic               vsync_d,
  output logic               display_on_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Bounds are compared on 11 bits so a 1024-wide raster still decodes.
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Level a sync output rests at when not asserted (also the reset fill).
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // Reject geometries the 10-bit counters cannot hold and over-long pipes.
  if (H_TOTAL > 1024) begin : g_bad_htotal
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_vtotal
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if ((PIPE_DELAY < 0) || (PIPE_DELAY > 15)) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be 0..15");
  end

  logic [9:0]         r_hpos;
  logic [9:0]         r_vpos;
  logic [FRAME_W-1:0] r_frame;
  logic               w_h_last;
  logic               w_v_last;
  logic [10:0]        w_hpos_x;
  logic [10:0]        w_vpos_x;
  logic               w_hsync_raw;
  logic               w_vsync_raw;
  logic               w_hsync;
  logic               w_vsync;
  logic               w_display_on;

  assign w_h_last = (r_hpos == H_LAST);
  assign w_v_last = (r_vpos == V_LAST);
  assign w_hpos_x = {1'b0, r_hpos};
  assign w_vpos_x = {1'b0, r_vpos};

  // Raster counters and frame counter; vpos steps only at the end of a line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hpos  <= 10'd0;
      r_vpos  <= 10'd0;
      r_frame <= '0;
    end else begin
      if (w_h_last) begin
        r_hpos <= 10'd0;
        if (w_v_last) begin
          r_vpos  <= 10'd0;
          r_frame <= r_frame + FRAME_W'(1);
        end else begin
          r_vpos  <= r_vpos + 10'd1;
        end
      end else begin
        r_hpos <= r_hpos + 10'd1;
      end
    end
  end

  // Pure decodes of the registered counters, zero latency vs hpos/vpos.
  always_comb begin
    w_display_on = 1'b0;
    w_hsync_raw  = 1'b0;
    w_vsync_raw  = 1'b0;
    if ((w_hpos_x < H_VIS) && (w_vpos_x < V_VIS)) begin
      w_display_on = 1'b1;
    end else begin
      w_display_on = 1'b0;
    end
    if ((w_hpos_x >= HS_BEGIN) && (w_hpos_x < HS_END)) begin
      w_hsync_raw = 1'b1;
    end else begin
      w_hsync_raw = 1'b0;
    end
    // vsync covers whole lines, horizontal blank included.
    if ((w_vpos_x >= VS_BEGIN) && (w_vpos_x < VS_END)) begin
      w_vsync_raw = 1'b1;
    end else begin
      w_vsync_raw = 1'b0;
    end
  end

  // Polarity is applied ahead of the delay line so the pipe carries pin levels.
  assign w_hsync = w_hsync_raw ^ SYNC_IDLE;
  assign w_vsync = w_vsync_raw ^ SYNC_IDLE;

  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign frame_cnt   = r_frame;
  assign display_on  = w_display_on;
  assign line_start  = (r_hpos == 10'd0);
  assign frame_start = (r_hpos == 10'd0) && (r_vpos == 10'd0);

  if (PIPE_DELAY == 0) begin : g_no_delay
    assign hsync_d      = w_hsync;
    assign vsync_d      = w_vsync;
    assign display_on_d = w_display_on;
  end else begin : g_delay
    logic [PIPE_DELAY-1:0] r_hs_pipe;
    logic [PIPE_DELAY-1:0] r_vs_pipe;
    logic [PIPE_DELAY-1:0] r_de_pipe;

    // Shift registers; reset fills every stage with the inactive level.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_hs_pipe <= {PIPE_DELAY{SYNC_IDLE}};
        r_vs_pipe <= {PIPE_DELAY{SYNC_IDLE}};
        r_de_pipe <= {PIPE_DELAY{1'b0}};
      end else begin
        r_hs_pipe[0] <= w_hsync;
        r_vs_pipe[0] <= w_vsync;
        r_de_pipe[0] <= w_display_on;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          r_hs_pipe[i] <= r_hs_pipe[i-1];
          r_vs_pipe[i] <= r_vs_pipe[i-1];
          r_de_pipe[i] <= r_de_pipe[i-1];
        end
      end
    end

    assign hsync_d      = r_hs_pipe[PIPE_DELAY-1];
    assign vsync_d      = r_vs_pipe[PIPE_DELAY-1];
    assign display_on_d = r_de_pipe[PIPE_DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three instances share clock and reset: a small raster (fast frames,
//   FRAME_W=2 so the frame counter wraps), the same small raster with
//   PIPE_DELAY=0 and active-high sync, and the default 640x480 geometry.
//   The reference model derives every output from the number of clock edges
//   since the last reset edge using plain division/modulo arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Small geometry: 25 x 15 = 375 cycles per frame.
  localparam int SH_A = 16, SH_F = 2, SH_S = 4, SH_B = 3;
  localparam int SV_A = 8,  SV_F = 2, SV_S = 2, SV_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] a_hpos, a_vpos, b_hpos, b_vpos, c_hpos, c_vpos;
  logic       a_de, a_ls, a_fs, a_hs, a_vs, a_ded;
  logic       b_de, b_ls, b_fs, b_hs, b_vs, b_ded;
  logic       c_de, c_ls, c_fs, c_hs, c_vs, c_ded;
  logic [1:0] a_fc;
  logic [7:0] b_fc, c_fc;

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .SYNC_ACTIVE_LOW(1), .PIPE_DELAY(2), .FRAME_W(2)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .hpos(a_hpos), .vpos(a_vpos),
    .display_on(a_de), .line_start(a_ls), .frame_start(a_fs),
    .frame_cnt(a_fc), .hsync_d(a_hs), .vsync_d(a_vs), .display_on_d(a_ded)
  );

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .SYNC_ACTIVE_LOW(0), .PIPE_DELAY(0), .FRAME_W(8)
  ) u_pass (
    .clk(clk), .rst_n(rst_n), .hpos(b_hpos), .vpos(b_vpos),
    .display_on(b_de), .line_start(b_ls), .frame_start(b_fs),
    .frame_cnt(b_fc), .hsync_d(b_hs), .vsync_d(b_vs), .display_on_d(b_ded)
  );

  vga_timing_gen u_dflt (
    .clk(clk), .rst_n(rst_n), .hpos(c_hpos), .vpos(c_vpos),
    .display_on(c_de), .line_start(c_ls), .frame_start(c_fs),
    .frame_cnt(c_fc), .hsync_d(c_hs), .vsync_d(c_vs), .display_on_d(c_ded)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (time %0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int h;
    int v;
    int f;
    bit de;
    bit ls;
    bit fs;
    bit hs;
    bit vs;
  } ref_t;

  // Expected undelayed state after t edges since the reset edge.
  function automatic ref_t ref_at(input longint t, input int ha, input int hf, input int hsw,
                                  input int hb, input int va, input int vf, input int vsw,
                                  input int vb, input bit sal, input int fw);
    ref_t   r;
    longint ht;
    longint vt;
    bit     hon;
    bit     von;
    ht    = ha + hf + hsw + hb;
    vt    = va + vf + vsw + vb;
    r.h   = int'(t % ht);
    r.v   = int'((t / ht) % vt);
    r.f   = int'((t / (ht * vt)) % (64'd1 << fw));
    r.de  = (r.h < ha) && (r.v < va);
    r.ls  = (r.h == 0);
    r.fs  = (r.h == 0) && (r.v == 0);
    hon   = (r.h >= ha + hf) && (r.h < ha + hf + hsw);
    von   = (r.v >= va + vf) && (r.v < va + vf + vsw);
    r.hs  = sal ? !hon : hon;
    r.vs  = sal ? !von : von;
    return r;
  endfunction

  task automatic check_dut(input string nm, input longint t,
                           input int ha, input int hf, input int hsw, input int hb,
                           input int va, input int vf, input int vsw, input int vb,
                           input bit sal, input int pd, input int fw,
                           input logic [9:0] hp, input logic [9:0] vp, input logic [31:0] fc,
                           input logic de, input logic ls, input logic fs,
                           input logic hsd, input logic vsd, input logic ded);
    ref_t now_r;
    ref_t old_r;
    bit   e_hs;
    bit   e_vs;
    bit   e_de;
    now_r = ref_at(t, ha, hf, hsw, hb, va, vf, vsw, vb, sal, fw);
    if (t >= pd) begin
      old_r = ref_at(t - pd, ha, hf, hsw, hb, va, vf, vsw, vb, sal, fw);
      e_hs  = old_r.hs;
      e_vs  = old_r.vs;
      e_de  = old_r.de;
    end else begin
      // Pipe still holds reset fill: syncs idle, display off.
      e_hs  = sal;
      e_vs  = sal;
      e_de  = 1'b0;
    end
    check_val({nm, ".hpos"},         32'(hp),  32'(now_r.h));
    check_val({nm, ".vpos"},         32'(vp),  32'(now_r.v));
    check_val({nm, ".frame_cnt"},    fc,       32'(now_r.f));
    check_val({nm, ".display_on"},   32'(de),  32'(now_r.de));
    check_val({nm, ".line_start"},   32'(ls),  32'(now_r.ls));
    check_val({nm, ".frame_start"},  32'(fs),  32'(now_r.fs));
    check_val({nm, ".hsync_d"},      32'(hsd), 32'(e_hs));
    check_val({nm, ".vsync_d"},      32'(vsd), 32'(e_vs));
    check_val({nm, ".display_on_d"}, 32'(ded), 32'(e_de));
  endtask

  longint t_edges = 0;
  bit     started = 1'b0;

  // Edges since the most recent edge that sampled rst_n low.
  always @(posedge clk) begin
    t_edges <= rst_n ? (t_edges + 64'd1) : 64'd0;
    started <= 1'b1;
  end

  // Compare all three instances against the model half a cycle after each edge.
  always @(negedge clk) begin
    if (started) begin
      check_dut("small", t_edges, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B,
                1'b1, 2, 2, a_hpos, a_vpos, 32'(a_fc), a_de, a_ls, a_fs, a_hs, a_vs, a_ded);
      check_dut("pass", t_edges, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B,
                1'b0, 0, 8, b_hpos, b_vpos, 32'(b_fc), b_de, b_ls, b_fs, b_hs, b_vs, b_ded);
      check_dut("dflt", t_edges, 640, 16, 96, 48, 480, 10, 2, 33,
                1'b1, 2, 8, c_hpos, c_vpos, 32'(c_fc), c_de, c_ls, c_fs, c_hs, c_vs, c_ded);
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    // Over five small frames without reset: frame_cnt counts to 3 and wraps.
    repeat (2000) @(negedge clk);
    // Random-length runs interrupted by short random mid-frame resets.
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(900, 1)) @(negedge clk);
      rst_n = 1'b0;
      repeat ($urandom_range(3, 1)) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (1200) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
